// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Runs one neural_layer pass over all M neurons of a layer. It can first
//   load M biases from a config stream. For each neuron it pulses
//   neural_layer start, then requests the row from the matrix engine and
//   waits for the activated result. Each result is handed downstream over a
//   valid/ready handshake.
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   run, reload_bias, act_type_in  pass start (IDLE only), bias reload, activation
//   abort                          drop back to IDLE from any busy state
//   cfg_bias/cfg_valid/cfg_ready   bias config stream
//   nl_bias_in/wen/addr            bias memory write port of neural_layer
//   nl_start, nl_activation_type   neural_layer control
//   nl_app_result, nl_app_valid    activated result from neural_layer
//   mm_req, mm_row                 one-cycle row request to the matrix engine
//   res_data/idx/valid/ready/last  downstream result stream
//   busy, done, timeout_err        status (done = 1-cycle pulse, err sticky)
module layer_sequencer #(
    parameter int M          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255,
    localparam int IW        = $clog2(M),
    localparam int TW        = $clog2(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    reload_bias,
    input  logic [1:0]              act_type_in,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   cfg_bias,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [DATA_WIDTH-1:0]   nl_bias_in,
    output logic                    nl_bias_wen,
    output logic [IW-1:0]           nl_bias_addr,
    output logic                    nl_start,
    output logic [1:0]              nl_activation_type,
    input  logic [2*DATA_WIDTH-1:0] nl_app_result,
    input  logic                    nl_app_valid,
    output logic                    mm_req,
    output logic [IW-1:0]           mm_row,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic [IW-1:0]           res_idx,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_last,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_BIAS, S_ARM, S_REQ, S_WAIT_APP, S_EMIT, S_DONE
    } state_t;

    state_t                  r_state, w_next;
    logic [IW-1:0]           r_idx, r_bias_cnt, r_res_idx;
    logic [TW-1:0]           r_timer;
    logic [1:0]              r_act;
    logic [2*DATA_WIDTH-1:0] r_res_data;
    logic                    r_timeout_err;
    logic                    w_is_last, w_timer_exp, w_abort;

    assign w_is_last   = (r_idx == IW'(M-1));
    assign w_timer_exp = (r_timer == TW'(TIMEOUT-1));
    assign w_abort     = abort && (r_state != S_IDLE);

    assign nl_bias_addr       = r_bias_cnt;
    assign nl_activation_type = r_act;
    assign mm_row             = r_idx;
    assign res_data           = r_res_data;
    assign res_idx            = r_res_idx;
    assign timeout_err        = r_timeout_err;

    always_comb begin
        w_next      = r_state;
        cfg_ready   = 1'b0;
        nl_bias_wen = 1'b0;
        nl_bias_in  = '0;
        nl_start    = 1'b0;
        mm_req      = 1'b0;
        res_valid   = 1'b0;
        res_last    = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                // abort alongside run keeps the block idle
                if (run && !abort) w_next = reload_bias ? S_LOAD_BIAS : S_ARM;
            end
            S_LOAD_BIAS: begin
                cfg_ready   = 1'b1;
                nl_bias_wen = cfg_valid;
                nl_bias_in  = cfg_bias;
                if (cfg_valid && r_bias_cnt == IW'(M-1)) w_next = S_ARM;
            end
            S_ARM: begin
                nl_start = 1'b1;
                w_next   = S_REQ;
            end
            S_REQ: begin
                mm_req = 1'b1;
                w_next = S_WAIT_APP;
            end
            S_WAIT_APP: begin
                if (nl_app_valid)     w_next = S_EMIT;
                else if (w_timer_exp) w_next = S_DONE;
            end
            S_EMIT: begin
                res_valid = 1'b1;
                res_last  = w_is_last;
                if (res_ready) w_next = w_is_last ? S_DONE : S_ARM;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_bias_cnt    <= '0;
            r_timer       <= '0;
            r_act         <= '0;
            r_res_data    <= '0;
            r_res_idx     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_abort) begin
                // a partial bias load must restart at address 0 next time
                r_bias_cnt <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (run && !abort) begin
                            r_act         <= act_type_in;
                            r_idx         <= '0;
                            r_bias_cnt    <= '0;
                            r_timeout_err <= 1'b0;
                        end
                    end
                    S_LOAD_BIAS: begin
                        if (cfg_valid)
                            r_bias_cnt <= (r_bias_cnt == IW'(M-1)) ? '0 : r_bias_cnt + IW'(1);
                    end
                    S_REQ: r_timer <= '0;
                    S_WAIT_APP: begin
                        if (nl_app_valid) begin
                            r_res_data <= nl_app_result;
                            r_res_idx  <= r_idx;
                        end else if (w_timer_exp) begin
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_EMIT: begin
                        if (res_ready && !w_is_last) r_idx <= r_idx + IW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboarded bench for layer_sequencer (M=3, DATA_WIDTH=8, TIMEOUT=8).
// A matrix-engine responder picks each row's result and queues the expected
// downstream beat; a monitor checks bias writes and result handshakes.
module tb_layer_sequencer;
    localparam int M  = 3;
    localparam int DW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst, run, reload_bias, abort, cfg_valid, cfg_ready;
    logic [1:0] act_type_in, nl_activation_type, nl_bias_addr, mm_row, res_idx;
    logic [DW-1:0] cfg_bias, nl_bias_in;
    logic nl_bias_wen, nl_start, nl_app_valid, mm_req, res_valid, res_ready;
    logic res_last, busy, done, timeout_err;
    logic [2*DW-1:0] nl_app_result, res_data;

    layer_sequencer #(.M(M), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run), .reload_bias(reload_bias),
        .act_type_in(act_type_in), .abort(abort), .cfg_bias(cfg_bias),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .nl_bias_in(nl_bias_in),
        .nl_bias_wen(nl_bias_wen), .nl_bias_addr(nl_bias_addr), .nl_start(nl_start),
        .nl_activation_type(nl_activation_type), .nl_app_result(nl_app_result),
        .nl_app_valid(nl_app_valid), .mm_req(mm_req), .mm_row(mm_row),
        .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid),
        .res_ready(res_ready), .res_last(res_last), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2*DW-1:0] data; logic [1:0] idx; logic last; } res_t;
    typedef struct { logic [1:0] addr; logic [DW-1:0] val; } bias_t;
    res_t  exp_q[$];
    bias_t bias_q[$];
    int    fixed_q[$];     // forced matrix results, else random
    int    bias_vals[$];   // forced bias beats, else random
    int    vectors = 0, miscompares = 0;
    int    exp_row = 0, start_cnt = 0, done_cnt = 0;
    bit    silent = 0, ready_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // matrix engine + neural_layer stand-in
    initial begin
        logic [2*DW-1:0] r;
        logic [1:0] row;
        nl_app_valid = 0; nl_app_result = '0;
        forever begin
            @(negedge clk);
            if (mm_req === 1'b1) begin
                row = mm_row;
                chk("mm_row", row, exp_row);
                exp_row++;
                if (!silent) begin
                    r = (fixed_q.size() != 0) ? (2*DW)'(fixed_q.pop_front()) : (2*DW)'($urandom);
                    exp_q.push_back('{data: r, idx: row, last: (row == M-1)});
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1 nl_app_valid = 1; nl_app_result = r;
                    @(posedge clk);
                    #1 nl_app_valid = 0; nl_app_result = (2*DW)'($urandom);
                    @(negedge clk);
                    chk("app_to_res_latency", res_valid, 1);
                end
            end
        end
    end

    initial begin
        res_ready = 0;
        forever begin
            @(posedge clk);
            #1 res_ready = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor
    initial begin
        bit hold_prev = 0;
        logic [2*DW-1:0] pd;
        logic [1:0] pi;
        bias_t b;
        res_t e;
        forever begin
            @(negedge clk);
            if (nl_bias_wen === 1'b1) begin
                if (bias_q.size() == 0) chk("bias_unexpected_write", 1, 0);
                else begin
                    b = bias_q.pop_front();
                    chk("bias_addr", nl_bias_addr, b.addr);
                    chk("bias_data", nl_bias_in, b.val);
                end
            end
            if (res_valid === 1'b1 && hold_prev) begin
                chk("res_stable_data", res_data, pd);
                chk("res_stable_idx", res_idx, pi);
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_idx", res_idx, e.idx);
                    chk("res_last", res_last, e.last);
                end
            end
            hold_prev = (res_valid === 1'b1) && (res_ready !== 1'b1);
            pd = res_data; pi = res_idx;
            if (nl_start === 1'b1) start_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk_zero(input string p);
        chk({p, "_busy"}, busy, 0);           chk({p, "_done"}, done, 0);
        chk({p, "_res_valid"}, res_valid, 0); chk({p, "_res_data"}, res_data, 0);
        chk({p, "_timeout_err"}, timeout_err, 0);
        chk({p, "_act"}, nl_activation_type, 0);
        chk({p, "_mm_req"}, mm_req, 0);       chk({p, "_nl_start"}, nl_start, 0);
        chk({p, "_cfg_ready"}, cfg_ready, 0); chk({p, "_mm_row"}, mm_row, 0);
    endtask

    task automatic do_run(input bit rl, input logic [1:0] at);
        @(posedge clk);
        #1 run = 1; reload_bias = rl; act_type_in = at; exp_row = 0;
        @(posedge clk);
        #1 run = 0; reload_bias = 1'($urandom); act_type_in = 2'($urandom);
    endtask

    task automatic send_beat(input logic [DW-1:0] v, input int a);
        bias_q.push_back('{addr: 2'(a), val: v});
        cfg_valid = 1; cfg_bias = v;
        @(posedge clk);
        #1 cfg_valid = 0; cfg_bias = DW'($urandom);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1; break; end
        end
        chk({nm, "_done_seen"}, seen, 1);
    endtask

    task automatic full_pass(input bit rl, input string nm);
        int s0, d0;
        bit fixed;
        logic [1:0] at;
        s0 = start_cnt; d0 = done_cnt; at = 2'($urandom);
        fixed = (bias_vals.size() != 0);
        do_run(rl, at);
        if (rl)
            for (int i = 0; i < M; i++) begin
                send_beat(fixed ? DW'(bias_vals.pop_front()) : DW'($urandom), i);
                if (!fixed && i < M-1)
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        @(negedge clk);
        chk({nm, "_run_to_start"}, nl_start, 1);
        chk({nm, "_act_type"}, nl_activation_type, at);
        wait_done(nm);
        @(negedge clk);
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_start_count"}, start_cnt - s0, M);
        chk({nm, "_all_results"}, exp_q.size(), 0);
        chk({nm, "_timeout_err"}, timeout_err, 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        int d0, n, s;
        bit seen;
        logic [2*DW-1:0] held;
        rst = 1; run = 0; reload_bias = 0; act_type_in = 0; abort = 0;
        cfg_bias = 0; cfg_valid = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;

        // bias load 5,-3,0 then results 10,20,30
        bias_vals = '{5, -3, 0};
        fixed_q = '{10, 20, 30};
        full_pass(1, "bias_load");
        fixed_q = '{10, 20, 30};
        full_pass(0, "basic");

        // downstream stall in EMIT
        ready_hold = 1;
        fork
            full_pass(0, "stall");
            begin
                seen = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (res_valid === 1'b1) begin seen = 1; break; end
                end
                chk("stall_res_seen", seen, 1);
                held = res_data; s = start_cnt;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid_held", res_valid, 1);
                    chk("stall_data_held", res_data, held);
                end
                chk("stall_no_extra_start", start_cnt, s);
                ready_hold = 0;
            end
        join

        // timeout: no app_valid after the request
        silent = 1; d0 = done_cnt;
        do_run(0, 2'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mm_req === 1'b1) begin seen = 1; break; end
        end
        chk("timeout_req_seen", seen, 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); n++;
            if (done === 1'b1) break;
        end
        chk("timeout_cycles_to_done", n, TO + 1);
        chk("timeout_err_set", timeout_err, 1);
        @(negedge clk);
        chk("timeout_done_once", done_cnt - d0, 1);
        chk("timeout_err_sticky", timeout_err, 1);
        silent = 0;
        full_pass(0, "after_timeout");

        // abort in LOAD_BIAS after one beat
        d0 = done_cnt;
        do_run(1, 2'd2);
        send_beat(8'h11, 0);
        abort = 1;
        @(posedge clk);
        #1 abort = 0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        chk("abort_cfg_ready", cfg_ready, 0);
        @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        full_pass(1, "after_abort");

        // abort together with run in IDLE
        @(posedge clk);
        #1 run = 1; abort = 1;
        @(posedge clk);
        #1 run = 0; abort = 0;
        @(negedge clk);
        chk("abort_beats_run", busy, 0);

        // async reset in WAIT_APP
        silent = 1;
        do_run(0, 2'd3);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mm_req === 1'b1) begin seen = 1; break; end
        end
        chk("rst_req_seen", seen, 1);
        @(posedge clk); #1;
        @(posedge clk); #3 rst = 1;
        #1 chk_zero("midrst");
        @(negedge clk); rst = 0;
        silent = 0;
        fixed_q = '{10, 20, 30};
        full_pass(0, "post_reset");

        for (int k = 0; k < 6; k++) full_pass(1'($urandom_range(0, 1)), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
